// File: rtl/branch_pkg.sv
// Shared encodings for the branch slot: compare opcodes, FSM states and the
// immediate sign-extension helper used by branch_ctrl.
package branch_pkg;

  localparam logic [1:0] BR_EQ = 2'b00;
  localparam logic [1:0] BR_NE = 2'b01;
  localparam logic [1:0] BR_LT = 2'b10;
  localparam logic [1:0] BR_GE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    EVAL  = 2'b01,
    FLUSH = 2'b10
  } state_t;

  function automatic logic [31:0] sext20(input logic [19:0] v);
    return {{12{v[19]}}, v};
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Decode-to-branch handshake, decoded fields and redirect/writeback results.
// Statistics counters exist only when BRANCH_CTRL_STATS_EN is defined.
interface branch_ctrl_if;

  logic        dec_valid;
  logic        dec_ready;
  logic        is_nop;
  logic        is_jmp;
  logic        is_imm_type;
  logic        zero_ext;
  logic [1:0]  op;
  logic [4:0]  rd;
  logic [19:0] imm;
  logic [31:0] pc;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] taken_cnt;
  logic [31:0] nottaken_cnt;
`endif

  modport master (
    output dec_valid, is_nop, is_jmp, is_imm_type, zero_ext, op, rd, imm,
           pc, rs1_val, rs2_val,
`ifdef BRANCH_CTRL_STATS_EN
    input  taken_cnt, nottaken_cnt,
`endif
    input  dec_ready, redirect_valid, redirect_pc, flush, stall,
           wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  dec_valid, is_nop, is_jmp, is_imm_type, zero_ext, op, rd, imm,
           pc, rs1_val, rs2_val,
`ifdef BRANCH_CTRL_STATS_EN
    output taken_cnt, nottaken_cnt,
`endif
    output dec_ready, redirect_valid, redirect_pc, flush, stall,
           wb_valid, wb_rd, wb_data
  );

endinterface

// File: rtl/branch_cmp.sv
// Combinational branch condition: eq/ne/lt/ge, lt/ge unsigned when zero_ext.
module branch_cmp
  import branch_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  input  logic        zero_ext,
  output logic        taken
);

  logic lt;

  always_comb begin
    lt = zero_ext ? (a < b) : ($signed(a) < $signed(b));
    taken = 1'b0;
    case (op)
      BR_EQ:   taken = (a == b);
      BR_NE:   taken = (a != b);
      BR_LT:   taken = lt;
      BR_GE:   taken = !lt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch-slot controller: evaluates a registered branch/jump bundle, redirects
// fetch and holds flush afterwards. BRANCH_CTRL_STATS_EN adds outcome counters.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  branch_ctrl_if.slave  bus
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        is_jmp_q, is_imm_q, zext_q;
  logic [1:0]  op_q;
  logic [4:0]  rd_q;
  logic [19:0] imm_q;
  logic [31:0] pc_q, rs1_q, rs2_q;

  logic [31:0] redirect_pc_q, wb_data_q;
  logic [4:0]  wb_rd_q;

  logic        accept, cond_taken, taken;
  logic [31:0] imm_sext, br_target, jalr_target, target, link;
  logic        dec_ready, stall, flush, redirect_valid, wb_valid;

  assign accept = bus.dec_valid && (state_q == IDLE);

  branch_cmp u_cmp (
    .a        (rs1_q),
    .b        (rs2_q),
    .op       (op_q),
    .zero_ext (zext_q),
    .taken    (cond_taken)
  );

  assign imm_sext    = sext20(imm_q);
  assign br_target   = pc_q + (imm_sext << 1);
  assign jalr_target = (rs1_q + imm_sext) & ~32'h1;
  assign target      = (is_jmp_q && is_imm_q) ? jalr_target : br_target;
  assign taken       = is_jmp_q || cond_taken;
  assign link        = pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    dec_ready      = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    wb_valid       = 1'b0;
    case (state_q)
      IDLE: begin
        dec_ready = 1'b1;
        if (accept && !bus.is_nop) state_d = EVAL;
      end
      EVAL: begin
        stall    = 1'b1;
        wb_valid = is_jmp_q && (rd_q != 5'd0);
        if (taken) begin
          redirect_valid = 1'b1;
          cnt_d          = FLUSH_LOAD;
          state_d        = FLUSH;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        stall = 1'b1;
        flush = 1'b1;
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_jmp_q <= 1'b0;
      is_imm_q <= 1'b0;
      zext_q   <= 1'b0;
      op_q     <= 2'b00;
      rd_q     <= 5'd0;
      imm_q    <= 20'd0;
      pc_q     <= 32'd0;
      rs1_q    <= 32'd0;
      rs2_q    <= 32'd0;
    end else if (accept && !bus.is_nop) begin
      is_jmp_q <= bus.is_jmp;
      is_imm_q <= bus.is_imm_type;
      zext_q   <= bus.zero_ext;
      op_q     <= bus.op;
      rd_q     <= bus.rd;
      imm_q    <= bus.imm;
      pc_q     <= bus.pc;
      rs1_q    <= bus.rs1_val;
      rs2_q    <= bus.rs2_val;
    end
  end

  // Result outputs show the live value while pulsing, the last one otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pc_q <= RESET_PC;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= 32'd0;
    end else begin
      if (redirect_valid) redirect_pc_q <= target;
      if (wb_valid) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= link;
      end
    end
  end

  assign bus.dec_ready      = dec_ready;
  assign bus.stall          = stall;
  assign bus.flush          = flush;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_valid ? target : redirect_pc_q;
  assign bus.wb_valid       = wb_valid;
  assign bus.wb_rd          = wb_valid ? rd_q : wb_rd_q;
  assign bus.wb_data        = wb_valid ? link : wb_data_q;

`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] taken_cnt_q, nottaken_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt_q    <= 32'd0;
      nottaken_cnt_q <= 32'd0;
    end else if (state_q == EVAL && !is_jmp_q) begin
      if (cond_taken) begin
        if (taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + 32'd1;
      end else begin
        if (nottaken_cnt_q != '1) nottaken_cnt_q <= nottaken_cnt_q + 32'd1;
      end
    end
  end

  assign bus.taken_cnt    = taken_cnt_q;
  assign bus.nottaken_cnt = nottaken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: expected redirects/writebacks are queued by
// the stimulus and consumed by an independent monitor on each pulse.
module tb_branch_ctrl;
  import branch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] redir_q[$];
  logic [36:0] wb_q[$];

  branch_ctrl_if bus ();

  branch_ctrl #(
    .FLUSH_CYCLES (2),
    .RESET_PC     (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every redirect or writeback pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.redirect_valid) begin
        if (redir_q.size() == 0) checkOutput("unexpected_redirect", 64'd1, 64'd0);
        else checkOutput("redirect_pc", {32'd0, bus.redirect_pc}, {32'd0, redir_q.pop_front()});
      end
      if (bus.wb_valid) begin
        if (wb_q.size() == 0) checkOutput("unexpected_wb", 64'd1, 64'd0);
        else checkOutput("wb_rd_data", {27'd0, bus.wb_rd, bus.wb_data}, {27'd0, wb_q.pop_front()});
      end
    end
  end

  task automatic applyStimulus(input string name, input logic jmp, input logic immt,
                               input logic zx, input logic [1:0] op, input logic [4:0] rd,
                               input logic [19:0] imm, input logic [31:0] pc,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic exp_redir, input logic [31:0] exp_pc,
                               input logic exp_wb, input logic [31:0] exp_link,
                               input int exp_lat, input int exp_flush);
    int cycles, fl, st;
    @(negedge clk);
    checkOutput({name, "_ready_before"}, {63'd0, bus.dec_ready}, 64'd1);
    bus.is_jmp      = jmp;
    bus.is_imm_type = immt;
    bus.zero_ext    = zx;
    bus.op          = op;
    bus.rd          = rd;
    bus.imm         = imm;
    bus.pc          = pc;
    bus.rs1_val     = rs1;
    bus.rs2_val     = rs2;
    bus.dec_valid   = 1'b1;
    if (exp_redir) redir_q.push_back(exp_pc);
    if (exp_wb) wb_q.push_back({rd, exp_link});
    @(posedge clk);
    #1 bus.dec_valid = 1'b0;
    cycles = 0;
    fl = 0;
    st = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (bus.flush) fl++;
      if (bus.stall) st++;
    end while (!bus.dec_ready && cycles < 40);
    checkOutput({name, "_latency"}, 64'(cycles), 64'(exp_lat));
    checkOutput({name, "_flush_cycles"}, 64'(fl), 64'(exp_flush));
    checkOutput({name, "_stall_cycles"}, 64'(st), 64'(exp_lat - 1));
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_dec_ready"}, {63'd0, bus.dec_ready}, 64'd1);
    checkOutput({name, "_stall"}, {63'd0, bus.stall}, 64'd0);
    checkOutput({name, "_flush"}, {63'd0, bus.flush}, 64'd0);
    checkOutput({name, "_redirect_valid"}, {63'd0, bus.redirect_valid}, 64'd0);
    checkOutput({name, "_wb_valid"}, {63'd0, bus.wb_valid}, 64'd0);
    checkOutput({name, "_redirect_pc"}, {32'd0, bus.redirect_pc}, 64'h0);
    checkOutput({name, "_wb_rd"}, {59'd0, bus.wb_rd}, 64'd0);
    checkOutput({name, "_wb_data"}, {32'd0, bus.wb_data}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.dec_valid   = 1'b0;
    bus.is_nop      = 1'b0;
    bus.is_jmp      = 1'b0;
    bus.is_imm_type = 1'b0;
    bus.zero_ext    = 1'b0;
    bus.op          = BR_EQ;
    bus.rd          = 5'd0;
    bus.imm         = 20'd0;
    bus.pc          = 32'd0;
    bus.rs1_val     = 32'd0;
    bus.rs2_val     = 32'd0;

    repeat (2) @(negedge clk);
    checkResetValues("in_reset");
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("after_reset");

    // name, jmp, immt, zx, op, rd, imm, pc, rs1, rs2, redir, pc, wb, link, lat, flush
    applyStimulus("beq_taken", 0, 0, 0, BR_EQ, 5'd0, 20'h00008, 32'h100, 32'd5, 32'd5,
                  1, 32'h110, 0, 32'h0, 4, 2);
    applyStimulus("bne_not_taken", 0, 0, 0, BR_NE, 5'd0, 20'h00008, 32'h180, 32'd5, 32'd5,
                  0, 32'h0, 0, 32'h0, 2, 0);
    checkOutput("redirect_pc_hold", {32'd0, bus.redirect_pc}, 64'h110);
    applyStimulus("blt_signed", 0, 0, 0, BR_LT, 5'd0, 20'hFFFFC, 32'h300, 32'hFFFFFFFF, 32'd1,
                  1, 32'h2F8, 0, 32'h0, 4, 2);
    applyStimulus("bltu", 0, 0, 1, BR_LT, 5'd0, 20'hFFFFC, 32'h300, 32'hFFFFFFFF, 32'd1,
                  0, 32'h0, 0, 32'h0, 2, 0);
    applyStimulus("bge_signed", 0, 0, 0, BR_GE, 5'd0, 20'h00001, 32'h40, 32'd1, 32'hFFFFFFFF,
                  1, 32'h42, 0, 32'h0, 4, 2);
    applyStimulus("bgeu", 0, 0, 1, BR_GE, 5'd0, 20'h00001, 32'h40, 32'd1, 32'hFFFFFFFF,
                  0, 32'h0, 0, 32'h0, 2, 0);
    applyStimulus("bne_neg_imm", 0, 0, 0, BR_NE, 5'd0, 20'h80000, 32'h10, 32'd5, 32'd6,
                  1, 32'hFFF00010, 0, 32'h0, 4, 2);
    applyStimulus("jalr", 1, 1, 0, BR_EQ, 5'd1, 20'h00004, 32'h200, 32'h1003, 32'd0,
                  1, 32'h1006, 1, 32'h204, 4, 2);
    applyStimulus("jal_rd0_wrap", 1, 0, 0, BR_EQ, 5'd0, 20'h00002, 32'hFFFFFFFC, 32'd0, 32'd0,
                  1, 32'h0, 0, 32'h0, 4, 2);

    // Reset during the first flush cycle of a taken branch.
    @(negedge clk);
    bus.is_jmp = 1'b0; bus.is_imm_type = 1'b0; bus.zero_ext = 1'b0;
    bus.op = BR_EQ; bus.rd = 5'd3; bus.imm = 20'h00010; bus.pc = 32'h500;
    bus.rs1_val = 32'd7; bus.rs2_val = 32'd7;
    bus.dec_valid = 1'b1;
    redir_q.push_back(32'h520);
    @(posedge clk);
    #1 bus.dec_valid = 1'b0;
    @(posedge clk);
    #1 checkOutput("flush_before_rst", {63'd0, bus.flush}, 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_flush_drop", {63'd0, bus.flush}, 64'd0);
    checkOutput("rst_stall_drop", {63'd0, bus.stall}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("after_abort");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("abort_idle_ready", {63'd0, bus.dec_ready}, 64'd1);
      checkOutput("abort_idle_flush", {63'd0, bus.flush | bus.stall}, 64'd0);
    end

    // NOP bundles are consumed without any visible effect.
    @(negedge clk);
    bus.is_nop    = 1'b1;
    bus.is_jmp    = 1'b1;
    bus.rd        = 5'd4;
    bus.dec_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("nop_ready", {63'd0, bus.dec_ready}, 64'd1);
      checkOutput("nop_stall", {63'd0, bus.stall}, 64'd0);
      checkOutput("nop_flush", {63'd0, bus.flush}, 64'd0);
    end
    bus.dec_valid = 1'b0;
    bus.is_nop    = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("redir_queue_drained", 64'(redir_q.size()), 64'd0);
    checkOutput("wb_queue_drained", 64'(wb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, number of cycles flush is held after a taken redirect (legal range 1..15).
REQ-002 Parameter: RESET_PC, default 32'h0, value of redirect_pc at reset.
REQ-003 Ports, in order: clk in 1 (single clock); rst in 1, asynchronous, active-high.
REQ-004 dec_valid in 1, decoded branch-slot bundle present; dec_ready out 1, block accepts bundle.
REQ-005 is_nop, is_jmp, is_imm_type, zero_ext in 1 each; op in 2; rd in 5; imm in 20: decoded branch-slot fields.
REQ-006 pc in 32, address of the bundle; rs1_val, rs2_val in 32 each, register operands valid with dec_valid.
REQ-007 redirect_valid out 1 (one-cycle pulse); redirect_pc out 32, fetch target.
REQ-008 flush out 1, kill younger bundles; stall out 1, hold fetch/decode.
REQ-009 wb_valid out 1 (one-cycle pulse); wb_rd out 5; wb_data out 32, link value.

Function
REQ-010 FSM states IDLE, EVAL, FLUSH; reset state IDLE.
REQ-011 dec_ready SHALL be 1 only in IDLE; a bundle is accepted when dec_valid && dec_ready.
REQ-012 Accepted bundle fields SHALL be registered; IDLE -> EVAL on accept, except is_nop accept stays IDLE with no outputs asserted.
REQ-013 stall SHALL be 1 in EVAL and FLUSH, 0 in IDLE.
REQ-014 Compare in EVAL: op 00 eq, 01 ne, 10 lt, 11 ge; lt/ge unsigned when zero_ext=1, else signed.
REQ-015 Conditional branch target = pc + ({sext(imm[19:0]) to 32} << 1), 32-bit wrap-around, no overflow flag.
REQ-016 JAL (is_jmp=1, is_imm_type=0): target = pc + (sext(imm) << 1); always taken.
REQ-017 JALR (is_jmp=1, is_imm_type=1): target = (rs1_val + sext(imm)) with bit 0 cleared; always taken.
REQ-018 Jumps SHALL pulse wb_valid in EVAL with wb_rd=rd, wb_data=pc+4; wb_valid SHALL NOT pulse if rd=0.
REQ-019 Taken in EVAL: redirect_valid=1 and redirect_pc=target for exactly that cycle; EVAL -> FLUSH.
REQ-020 Not taken in EVAL: no redirect, no flush; EVAL -> IDLE (one stall cycle total).
REQ-021 flush SHALL be 1 for exactly FLUSH_CYCLES cycles in FLUSH, counted by a 4-bit down-counter; FLUSH -> IDLE when it reaches 0.
REQ-022 redirect_pc SHALL hold last value between pulses; wb_rd/wb_data are don't-care when wb_valid=0.
REQ-023 Latency: accept at cycle N -> redirect/wb at cycle N+1 -> dec_ready again at N+2 (not taken) or N+2+FLUSH_CYCLES (taken).

Reset
REQ-024 rst asynchronously forces IDLE, counter 0, redirect_valid/flush/stall/wb_valid 0, dec_ready 1 after release, redirect_pc RESET_PC, wb_rd 0, wb_data 0.
REQ-025 rst mid-EVAL or mid-FLUSH SHALL abort immediately; no redirect or wb pulse after release for the aborted bundle.

Configuration
REQ-026 Macro BRANCH_CTRL_STATS_EN: when defined, adds outputs taken_cnt and nottaken_cnt (32 each) counting conditional-branch outcomes in EVAL, saturating at all-ones, cleared by rst; when undefined, ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-027 Shared package branch_pkg SHALL hold the op encodings (BR_EQ=00, BR_NE=01, BR_LT=10, BR_GE=11) and the FSM state enum.
REQ-028 One sub-module branch_cmp: combinational compare (a, b, op, zero_ext -> taken); target/link arithmetic stays in branch_ctrl.

Verification
REQ-029 BEQ rs1=rs2=5, pc=0x100, imm=0x00008 -> redirect_pc=0x110 at N+1, flush high 2 cycles, dec_ready at N+4.
REQ-030 BLT signed rs1=0xFFFFFFFF, rs2=1 -> taken; same with zero_ext=1 (BLTU) -> not taken, dec_ready at N+2, flush never high.
REQ-031 JALR rs1=0x1003, imm=0x00004, rd=1, pc=0x200 -> redirect_pc=0x1006, wb_rd=1, wb_data=0x204.
REQ-032 JAL rd=0, pc=0xFFFFFFFC, imm=0x00002 -> redirect_pc=0x00000000 (wrap), no wb_valid.
REQ-033 Taken branch with rst asserted during first FLUSH cycle -> flush/stall drop immediately, IDLE after release, no further pulses.
REQ-034 is_nop with dec_valid for 3 cycles -> dec_ready stays 1, stall/flush/redirect/wb never asserted.
